// File: rtl/hls_vector_runner_if.sv
// ap_ctrl_hs block-level handshake between the vector runner and the core under test.
interface hls_vector_runner_if #(
    parameter int ARG_W = 32,
    parameter int RET_W = 64
);
    logic             ap_start;
    logic [ARG_W-1:0] ap_arg;
    logic             ap_done;
    logic             ap_ready;
    logic             ap_idle;
    logic [RET_W-1:0] ap_return;

    // Runner side: launches the core and collects its result.
    modport master (
        output ap_start,
        output ap_arg,
        input  ap_done,
        input  ap_ready,
        input  ap_idle,
        input  ap_return
    );

    // Core side: accepts a launch and reports completion.
    modport slave (
        input  ap_start,
        input  ap_arg,
        output ap_done,
        output ap_ready,
        output ap_idle,
        output ap_return
    );
endinterface

// File: rtl/hls_vector_runner.sv
// Stimulus/check sequencer: replays stored argument/golden pairs through an
// ap_ctrl_hs core, compares every return value and keeps pass/fail statistics.
module hls_vector_runner #(
    parameter int ARG_W   = 32,
    parameter int RET_W   = 64,
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_we,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [ARG_W-1:0]    load_arg,
    input  logic [RET_W-1:0]    load_gold,
    input  logic [ADDR_W:0]     num_vec,
    input  logic                stop_on_fail,
    input  logic                start,
    output logic                busy,
    output logic                done,
    hls_vector_runner_if.master hs,
    output logic [CNT_W-1:0]    pass_cnt,
    output logic [CNT_W-1:0]    fail_cnt,
    output logic                first_fail_valid,
    output logic [ADDR_W-1:0]   first_fail_idx,
    output logic [RET_W-1:0]    last_result,
    output logic                timeout_flag
);
    // Storage is sized to the full address space so any address indexes legally;
    // only the first DEPTH slots are ever written.
    localparam int                SLOTS   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam int                TO_W    = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_CHECK = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    logic [ARG_W-1:0]  arg_mem [SLOTS];
    logic [RET_W-1:0]  gold_mem [SLOTS];
    logic [ARG_W-1:0]  arg_q_r;
    logic [RET_W-1:0]  gold_q_r;
    logic [ADDR_W-1:0] ram_addr_s;
    logic              ram_we_s;

    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W:0]   nvec_r;
    logic              sof_r;
    logic [RET_W-1:0]  gold_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              ap_start_r;
    logic [ARG_W-1:0]  ap_arg_r;

    logic [ADDR_W:0]   nvec_clamp_s;
    logic              last_vec_s;
    logic              mismatch_s;

    logic              go_s;
    logic              latch_s;
    logic              launch_s;
    logic              drop_s;
    logic              tick_s;
    logic              capture_s;
    logic              tmo_s;
    logic              pass_s;
    logic              fail_s;
    logic              advance_s;
    logic              fin_s;

    // ap_idle carries no control meaning here; it is accepted and left unused.
    logic              idle_unused_s;

    assign hs.ap_start    = ap_start_r;
    assign hs.ap_arg      = ap_arg_r;
    assign idle_unused_s  = hs.ap_idle;

    // Saturating increment for the pass/fail statistics.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    assign nvec_clamp_s = (num_vec > DEPTH_C) ? DEPTH_C : num_vec;
    assign last_vec_s   = (({1'b0, idx_r} + (ADDR_W + 1)'(1)) == nvec_r);
    assign mismatch_s   = (last_result != gold_r);

    // Shared RAM address: the load port owns it only while idle.
    always_comb begin
        ram_addr_s = idx_r;
        ram_we_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            ram_addr_s = load_addr;
            ram_we_s   = load_we && ({1'b0, load_addr} < DEPTH_C);
        end else begin
            ram_addr_s = idx_r;
            ram_we_s   = 1'b0;
        end
    end

    // Single-port vector RAMs with a one-cycle registered read.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            arg_mem[ram_addr_s]  <= load_arg;
            gold_mem[ram_addr_s] <= load_gold;
        end
        arg_q_r  <= arg_mem[ram_addr_s];
        gold_q_r <= gold_mem[ram_addr_s];
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-state action strobes for the datapath.
    always_comb begin
        state_next_s = state_r;
        go_s         = 1'b0;
        latch_s      = 1'b0;
        launch_s     = 1'b0;
        drop_s       = 1'b0;
        tick_s       = 1'b0;
        capture_s    = 1'b0;
        tmo_s        = 1'b0;
        pass_s       = 1'b0;
        fail_s       = 1'b0;
        advance_s    = 1'b0;
        fin_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    go_s = 1'b1;
                    if (nvec_clamp_s == {(ADDR_W + 1){1'b0}}) begin
                        state_next_s = ST_FIN;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: state_next_s = ST_LATCH;
            ST_LATCH: begin
                latch_s      = 1'b1;
                state_next_s = ST_START;
            end
            ST_START: begin
                launch_s     = 1'b1;
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                // ap_done wins over the timeout and also counts as ap_ready.
                if (hs.ap_done) begin
                    capture_s    = 1'b1;
                    drop_s       = 1'b1;
                    state_next_s = ST_CHECK;
                end else if (to_cnt_r == TO_LAST) begin
                    tmo_s        = 1'b1;
                    drop_s       = 1'b1;
                    state_next_s = ST_FIN;
                end else begin
                    tick_s       = 1'b1;
                    drop_s       = hs.ap_ready;
                    state_next_s = ST_WAIT;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    fail_s = 1'b1;
                    if (last_vec_s || sof_r) begin
                        state_next_s = ST_FIN;
                    end else begin
                        advance_s    = 1'b1;
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    pass_s = 1'b1;
                    if (last_vec_s) begin
                        state_next_s = ST_FIN;
                    end else begin
                        advance_s    = 1'b1;
                        state_next_s = ST_FETCH;
                    end
                end
            end
            ST_FIN: begin
                fin_s        = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs driven by the sequencer strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            ap_start_r       <= 1'b0;
            ap_arg_r         <= {ARG_W{1'b0}};
            pass_cnt         <= {CNT_W{1'b0}};
            fail_cnt         <= {CNT_W{1'b0}};
            first_fail_valid <= 1'b0;
            first_fail_idx   <= {ADDR_W{1'b0}};
            last_result      <= {RET_W{1'b0}};
            timeout_flag     <= 1'b0;
            idx_r            <= {ADDR_W{1'b0}};
            nvec_r           <= {(ADDR_W + 1){1'b0}};
            sof_r            <= 1'b0;
            gold_r           <= {RET_W{1'b0}};
            to_cnt_r         <= {TO_W{1'b0}};
        end else begin
            done <= 1'b0;
            if (go_s) begin
                busy             <= 1'b1;
                pass_cnt         <= {CNT_W{1'b0}};
                fail_cnt         <= {CNT_W{1'b0}};
                first_fail_valid <= 1'b0;
                first_fail_idx   <= {ADDR_W{1'b0}};
                timeout_flag     <= 1'b0;
                idx_r            <= {ADDR_W{1'b0}};
                nvec_r           <= nvec_clamp_s;
                sof_r            <= stop_on_fail;
            end
            if (latch_s) begin
                ap_arg_r <= arg_q_r;
                gold_r   <= gold_q_r;
            end
            if (launch_s) begin
                ap_start_r <= 1'b1;
                to_cnt_r   <= {TO_W{1'b0}};
            end
            if (drop_s) begin
                ap_start_r <= 1'b0;
            end
            if (tick_s) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
            if (capture_s) begin
                last_result <= hs.ap_return;
            end
            if (tmo_s || fail_s) begin
                fail_cnt <= sat_inc(fail_cnt);
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= idx_r;
                end
            end
            if (tmo_s) begin
                timeout_flag <= 1'b1;
            end
            if (pass_s) begin
                pass_cnt <= sat_inc(pass_cnt);
            end
            if (advance_s) begin
                idx_r <= idx_r + ADDR_W'(1);
            end
            if (fin_s) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end
endmodule
